// File: rtl/xb_msg_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : xb_msg_endpoint (with helper xb_fifo)
// Purpose  : Host-side crossbar message endpoint: two independent FWFT FIFOs,
//            host->application (pending/ack) and application->host (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================

module xb_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam logic [DEPTH_LOG2:0]   c_depth   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   c_cnt_one = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] c_ptr_one = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    // Overfull pushes and empty pops are dropped here, so callers may pass raw requests.
    assign w_do_push = i_push && (r_count != c_depth);
    assign w_do_pop  = i_pop  && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    // Head is forced to zero when empty so stale memory never leaks out.
    assign o_empty = (r_count == '0);
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

module xb_msg_endpoint #(
    parameter int XB_SIZE    = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  host_wr_valid,
    output logic                  host_wr_ready,
    input  logic [XB_SIZE-1:0]    host_wr_data,
    output logic                  pc_msg_pending,
    input  logic                  pc_msg_ack,
    output logic [XB_SIZE-1:0]    pc_msg,
    input  logic                  fpga_msg_valid,
    input  logic [XB_SIZE-1:0]    fpga_msg,
    output logic                  fpga_msg_full,
    output logic                  host_rd_valid,
    input  logic                  host_rd_ready,
    output logic [XB_SIZE-1:0]    host_rd_data,
    output logic [DEPTH_LOG2:0]   pc_count,
    output logic [DEPTH_LOG2:0]   fpga_count,
    output logic                  fpga_overflow
);

    localparam logic [DEPTH_LOG2:0] c_depth   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] c_cnt_one = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic                w_pc_push;
    logic                w_pc_pop;
    logic                w_pc_empty;
    logic [DEPTH_LOG2:0] w_pc_count_next;
    logic                w_fpga_push;
    logic                w_fpga_pop;
    logic                w_fpga_empty;
    logic                r_wr_ready;
    logic                r_overflow;

    // ---------------- downstream: host -> application ----------------
    assign w_pc_push = host_wr_valid && r_wr_ready;
    assign w_pc_pop  = pc_msg_ack && !w_pc_empty;

    xb_fifo #(
        .WIDTH      (XB_SIZE),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_pc_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .i_push  (w_pc_push),
        .i_data  (host_wr_data),
        .i_pop   (w_pc_pop),
        .o_data  (pc_msg),
        .o_empty (w_pc_empty),
        .o_count (pc_count)
    );

    always_comb begin
        w_pc_count_next = pc_count;
        if (w_pc_push && !w_pc_pop) begin
            w_pc_count_next = pc_count + c_cnt_one;
        end else if (!w_pc_push && w_pc_pop) begin
            w_pc_count_next = pc_count - c_cnt_one;
        end
    end

    // Ready is a flop fed by the next occupancy, so an ack never reaches it combinationally.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ready <= 1'b0;
        end else begin
            r_wr_ready <= (w_pc_count_next != c_depth);
        end
    end

    assign host_wr_ready  = r_wr_ready;
    assign pc_msg_pending = !w_pc_empty;

    // ---------------- upstream: application -> host ----------------
    assign w_fpga_push = fpga_msg_valid && (fpga_count != c_depth);
    assign w_fpga_pop  = host_rd_ready && !w_fpga_empty;

    xb_fifo #(
        .WIDTH      (XB_SIZE),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fpga_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .i_push  (w_fpga_push),
        .i_data  (fpga_msg),
        .i_pop   (w_fpga_pop),
        .o_data  (host_rd_data),
        .o_empty (w_fpga_empty),
        .o_count (fpga_count)
    );

    // A write arriving while the FIFO is full is lost even if the host pops that cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_overflow <= 1'b0;
        end else if (fpga_msg_valid && (fpga_count == c_depth)) begin
            r_overflow <= 1'b1;
        end
    end

    // One slot of headroom absorbs the application's registered valid.
    assign fpga_msg_full = (fpga_count >= (c_depth - c_cnt_one));
    assign host_rd_valid = !w_fpga_empty;
    assign fpga_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_xb_msg_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : tb_xb_msg_endpoint
// Purpose  : Self-checking bench for xb_msg_endpoint against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xb_msg_endpoint;

    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        host_wr_valid;
    logic        host_wr_ready;
    logic [31:0] host_wr_data;
    logic        pc_msg_pending;
    logic        pc_msg_ack;
    logic [31:0] pc_msg;
    logic        fpga_msg_valid;
    logic [31:0] fpga_msg;
    logic        fpga_msg_full;
    logic        host_rd_valid;
    logic        host_rd_ready;
    logic [31:0] host_rd_data;
    logic [4:0]  pc_count;
    logic [4:0]  fpga_count;
    logic        fpga_overflow;

    xb_msg_endpoint #(
        .XB_SIZE    (32),
        .DEPTH_LOG2 (4)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .host_wr_valid  (host_wr_valid),
        .host_wr_ready  (host_wr_ready),
        .host_wr_data   (host_wr_data),
        .pc_msg_pending (pc_msg_pending),
        .pc_msg_ack     (pc_msg_ack),
        .pc_msg         (pc_msg),
        .fpga_msg_valid (fpga_msg_valid),
        .fpga_msg       (fpga_msg),
        .fpga_msg_full  (fpga_msg_full),
        .host_rd_valid  (host_rd_valid),
        .host_rd_ready  (host_rd_ready),
        .host_rd_data   (host_rd_data),
        .pc_count       (pc_count),
        .fpga_count     (fpga_count),
        .fpga_overflow  (fpga_overflow)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: contents of each direction as plain queues.
    logic [31:0] pq[$];
    logic [31:0] fq[$];
    bit          m_wr_ready;
    bit          m_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pq.delete();
        fq.delete();
        m_wr_ready = 1'b0;
        m_ovf      = 1'b0;
    endtask

    task automatic model_update();
        bit pc_push, pc_pop, f_push, f_pop;
        if (RESET) begin
            model_reset();
            return;
        end
        pc_pop  = pc_msg_ack && (pq.size() > 0);
        pc_push = host_wr_valid && m_wr_ready;
        if (pc_pop)  pq.delete(0);
        if (pc_push) pq.push_back(host_wr_data);
        m_wr_ready = (pq.size() != DEPTH);

        f_pop  = host_rd_ready && (fq.size() > 0);
        f_push = 1'b0;
        if (fpga_msg_valid) begin
            if (fq.size() < DEPTH) f_push = 1'b1;
            else                   m_ovf  = 1'b1;
        end
        if (f_pop)  fq.delete(0);
        if (f_push) fq.push_back(fpga_msg);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic compare_all();
        check("pc_msg_pending", pc_msg_pending, pq.size() != 0);
        check("pc_msg",         pc_msg,         (pq.size() != 0) ? pq[0] : 32'h0);
        check("pc_count",       pc_count,       pq.size());
        check("host_wr_ready",  host_wr_ready,  m_wr_ready);
        check("host_rd_valid",  host_rd_valid,  fq.size() != 0);
        check("host_rd_data",   host_rd_data,   (fq.size() != 0) ? fq[0] : 32'h0);
        check("fpga_count",     fpga_count,     fq.size());
        check("fpga_msg_full",  fpga_msg_full,  fq.size() >= DEPTH - 1);
        check("fpga_overflow",  fpga_overflow,  m_ovf);
    endtask

    always @(negedge CLK) compare_all();

    initial begin
        RESET          = 1'b1;
        host_wr_valid  = 1'b0;
        host_wr_data   = '0;
        pc_msg_ack     = 1'b0;
        fpga_msg_valid = 1'b0;
        fpga_msg       = '0;
        host_rd_ready  = 1'b0;
        model_reset();
        repeat (3) tick();

        check("rst_wr_ready", host_wr_ready, 0);
        check("rst_pending",  pc_msg_pending, 0);
        check("rst_pc_msg",   pc_msg, 0);
        check("rst_full",     fpga_msg_full, 0);
        check("rst_ovf",      fpga_overflow, 0);
        check("rst_rd_valid", host_rd_valid, 0);

        RESET = 1'b0;
        tick();
        check("wr_ready_after_release", host_wr_ready, 1);

        // Single message through the downstream path.
        host_wr_valid = 1'b1;
        host_wr_data  = 32'hA5A5_0001;
        tick();
        host_wr_valid = 1'b0;
        check("single_pending", pc_msg_pending, 1);
        check("single_pc_msg",  pc_msg, 32'hA5A5_0001);
        check("single_count",   pc_count, 1);
        tick();
        pc_msg_ack = 1'b1;
        tick();
        pc_msg_ack = 1'b0;
        check("single_pending_after_ack", pc_msg_pending, 0);
        check("single_count_after_ack",   pc_count, 0);

        // Fill downstream, offer a 17th word, then drain across the pointer wrap.
        host_wr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            host_wr_data = i;
            tick();
        end
        check("fill_wr_ready", host_wr_ready, 0);
        check("fill_count",    pc_count, 16);
        host_wr_data = 32'd99;
        tick();
        check("fill_17th_count", pc_count, 16);
        check("fill_17th_head",  pc_msg, 0);
        host_wr_valid = 1'b0;
        pc_msg_ack    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_order", pc_msg, i);
            tick();
        end
        pc_msg_ack = 1'b0;
        check("drain_empty", pc_msg_pending, 0);

        // Steady push+ack at occupancy 5.
        host_wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_wr_data = 100 + i;
            tick();
        end
        pc_msg_ack = 1'b1;
        for (int k = 0; k < 40; k++) begin
            host_wr_data = 105 + k;
            tick();
        end
        check("steady_count", pc_count, 5);
        check("steady_head",  pc_msg, 140);
        host_wr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("steady_drain", pc_msg, 140 + i);
            tick();
        end
        pc_msg_ack = 1'b0;

        // Upstream full/overflow boundary.
        fpga_msg_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            fpga_msg = 32'hF000 + i;
            tick();
        end
        check("up14_full",  fpga_msg_full, 0);
        check("up14_count", fpga_count, 14);
        fpga_msg = 32'hF000 + 14;
        tick();
        check("up15_full",  fpga_msg_full, 1);
        check("up15_count", fpga_count, 15);
        fpga_msg = 32'hF000 + 15;
        tick();
        check("up16_count", fpga_count, 16);
        check("up16_ovf",   fpga_overflow, 0);
        fpga_msg = 32'hDEAD;
        tick();
        check("up17_count", fpga_count, 16);
        check("up17_ovf",   fpga_overflow, 1);
        fpga_msg_valid = 1'b0;
        host_rd_ready  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("up_drain", host_rd_data, 32'hF000 + i);
            tick();
        end
        check("up_drained_valid", host_rd_valid, 0);
        check("up_ovf_sticky",    fpga_overflow, 1);

        // Pops while empty.
        pc_msg_ack = 1'b1;
        tick();
        pc_msg_ack = 1'b0;
        check("empty_ack_count",   pc_count, 0);
        check("empty_ack_pending", pc_msg_pending, 0);
        tick();
        check("empty_rd_valid", host_rd_valid, 0);
        host_rd_ready = 1'b0;

        // Asynchronous reset with both FIFOs holding 7 words.
        host_wr_valid  = 1'b1;
        fpga_msg_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            host_wr_data = 200 + i;
            fpga_msg     = 300 + i;
            tick();
        end
        host_wr_valid  = 1'b0;
        fpga_msg_valid = 1'b0;
        check("pre_rst_pc_count",   pc_count, 7);
        check("pre_rst_fpga_count", fpga_count, 7);
        #2;
        RESET = 1'b1;
        model_reset();
        #1;
        check("async_pc_count",   pc_count, 0);
        check("async_fpga_count", fpga_count, 0);
        check("async_pending",    pc_msg_pending, 0);
        check("async_rd_valid",   host_rd_valid, 0);
        check("async_wr_ready",   host_wr_ready, 0);
        check("async_ovf",        fpga_overflow, 0);
        check("async_pc_msg",     pc_msg, 0);
        check("async_rd_data",    host_rd_data, 0);
        tick();
        tick();
        RESET = 1'b0;
        tick();
        host_wr_valid = 1'b1;
        host_wr_data  = 32'h1234_5678;
        tick();
        host_wr_valid = 1'b0;
        check("post_rst_pc_msg", pc_msg, 32'h1234_5678);
        check("post_rst_count",  pc_count, 1);

        // Randomized traffic in three bias phases.
        for (int ph = 0; ph < 3; ph++) begin
            int pw, pa;
            pw = (ph == 0) ? 80 : (ph == 1) ? 30 : 55;
            pa = (ph == 0) ? 30 : (ph == 1) ? 80 : 55;
            for (int c = 0; c < 1000; c++) begin
                host_wr_valid  = ($urandom_range(99) < pw);
                host_wr_data   = $urandom;
                pc_msg_ack     = ($urandom_range(99) < pa);
                fpga_msg_valid = ($urandom_range(99) < pw);
                fpga_msg       = $urandom;
                host_rd_ready  = ($urandom_range(99) < pa);
                tick();
            end
        end
        host_wr_valid  = 1'b0;
        pc_msg_ack     = 1'b0;
        fpga_msg_valid = 1'b0;
        host_rd_ready  = 1'b0;
        tick();
        @(negedge CLK);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xb_msg_endpoint.md
Name: xb_msg_endpoint

Overview:
- Host-side end of the PC<->FPGA message crossbar; the application block's message ports connect directly to it.
- Downstream path: buffers host-written messages and presents them to the application on the pending/ack handshake.
- Upstream path: accepts application messages on the valid/full handshake and drains them to the host-side DMA logic over valid/ready.
- Two independent first-word-fall-through (FWFT) FIFOs sharing one clock.

Parameters:
XB_SIZE, 32, message width in bits (both directions)
DEPTH_LOG2, 4, log2 of each FIFO depth (DEPTH = 16)

Ports:
CLK  in  1  sole clock; all state updates on rising edge
RESET  in  1  asynchronous, active-high reset
host_wr_valid  in  1  host offers a downstream message
host_wr_ready  out  1  downstream FIFO can accept
host_wr_data  in  XB_SIZE  downstream message
pc_msg_pending  out  1  downstream FIFO non-empty
pc_msg_ack  in  1  application consumes head message
pc_msg  out  XB_SIZE  head of downstream FIFO
fpga_msg_valid  in  1  application writes upstream message (registered in app)
fpga_msg  in  XB_SIZE  upstream message
fpga_msg_full  out  1  upstream FIFO near full; application must stop
host_rd_valid  out  1  upstream FIFO non-empty
host_rd_ready  in  1  host accepts head
host_rd_data  out  XB_SIZE  head of upstream FIFO
pc_count  out  DEPTH_LOG2+1  downstream occupancy
fpga_count  out  DEPTH_LOG2+1  upstream occupancy
fpga_overflow  out  1  sticky: upstream write dropped

Behaviour:
- Reset (async assert, sync release): both FIFOs empty, counts 0, pointers 0.
  - pc_msg_pending=0, host_rd_valid=0, fpga_msg_full=0, fpga_overflow=0.
  - host_wr_ready=1 on the first edge after release; 0 while RESET is high.
  - pc_msg and host_rd_data = 0 while empty.
- Reset mid-transfer discards all buffered messages; no partial state survives.
- Downstream push: host_wr_valid & host_wr_ready at edge N stores the word.
  - pc_msg_pending rises and pc_msg is valid from edge N onward (1-cycle latency, FWFT).
- Downstream pop: pc_msg_ack & pc_msg_pending at an edge advances the read pointer.
  - The next word is presented in the same cycle the pointer moves.
  - pc_msg_ack while pc_msg_pending=0 is ignored; no count underflow.
- host_wr_ready = (pc_count != DEPTH), registered-equivalent.
  - A pop in the same cycle as full does not raise ready in that cycle.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, both operations performed.
- Simultaneous push and pop when empty: the push is stored, the pop is ignored, count becomes 1.
- Upstream push: fpga_msg_valid at an edge stores fpga_msg when fpga_count < DEPTH.
  - At DEPTH, the word is dropped and fpga_overflow sets; it clears only on RESET.
- fpga_msg_full = (fpga_count >= DEPTH-1).
  - The one-slot margin covers the application's registered valid, which reacts one cycle late.
- Upstream pop: host_rd_valid & host_rd_ready at an edge advances the read pointer.
  - Same simultaneous-event rules as downstream.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. Counts are DEPTH_LOG2+1 bits, range 0..DEPTH.
- Message data passes through unmodified. Order is strictly FIFO in each direction; the two directions are fully independent.

Test Plan:
- Reset, then one host write of 32'hA5A5_0001 at edge 1 -> pc_msg_pending=1 and pc_msg=32'hA5A5_0001 after edge 1; ack at edge 3 -> pending=0, pc_count=0.
- 16 back-to-back host writes with no ack -> host_wr_ready=0 after the 16th, pc_count=16; a 17th valid is not accepted; 16 acks return data 0..15 in order, with pointer wrap exercised.
- Steady push and ack every cycle from count 5 for 40 cycles -> pc_count holds at 5, no loss, sequence preserved across wraps.
- Application writes 15 words with host_rd_ready=0 -> fpga_msg_full=1 at count 15; a 16th write is accepted (count 16); a 17th is dropped, fpga_overflow=1, and the drained data are the 16 written words in order.
- pc_msg_ack pulse while empty -> no state change, pc_count stays 0; empty upstream FIFO with host_rd_ready=1 -> host_rd_valid stays 0.
- Assert RESET asynchronously mid-cycle with both FIFOs holding 7 words -> all outputs go to reset values immediately; after release, the first new word is presented correctly.
